// File: rtl/spi_fl_pkg.sv
// Shared encodings for the flash command sequencer: op codes, FSM states,
// flash opcodes, spi_master_fl commtype values and the frame descriptor.
package spi_fl_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_PROGRAM = 2'd1,
        OP_ERASE   = 2'd2,
        OP_RDSR    = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // Which transaction the next ISSUE launches.
    typedef enum logic [2:0] {
        STEP_READ = 3'd0,
        STEP_WREN = 3'd1,
        STEP_MAIN = 3'd2,
        STEP_POLL = 3'd3,
        STEP_RDSR = 3'd4
    } step_e;

    localparam logic [7:0] FL_WREN  = 8'h06;
    localparam logic [7:0] FL_FREAD = 8'h0B;
    localparam logic [7:0] FL_PP    = 8'h02;
    localparam logic [7:0] FL_SE    = 8'h20;
    localparam logic [7:0] FL_RDSR  = 8'h05;

    localparam logic [2:0] CMD_ONLY  = 3'd0;
    localparam logic [2:0] CMD_RD    = 3'd1;
    localparam logic [2:0] ADDR_RD   = 3'd2;
    localparam logic [2:0] CMD_WR    = 3'd3;
    localparam logic [2:0] ADDR_WR   = 3'd4;
    localparam logic [2:0] ADDR_ONLY = 3'd5;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic [31:0] din;
        logic [2:0]  ctype;
        logic [6:0]  nmiso;
        logic [3:0]  dummy;
    } fl_frame_t;

    function automatic fl_frame_t frame_for(input step_e step, input op_e op,
                                            input logic [23:0] addr,
                                            input logic [31:0] wdata);
        fl_frame_t f;
        f = '0;
        case (step)
            STEP_READ: begin
                f.cmd   = FL_FREAD;
                f.ctype = ADDR_RD;
                f.addr  = addr;
                f.nmiso = 7'd32;
                f.dummy = 4'd8;
            end
            STEP_WREN: begin
                f.cmd   = FL_WREN;
                f.ctype = CMD_ONLY;
            end
            STEP_MAIN: begin
                f.addr = addr;
                if (op == OP_PROGRAM) begin
                    f.cmd   = FL_PP;
                    f.ctype = ADDR_WR;
                    f.din   = wdata;
                end else begin
                    f.cmd   = FL_SE;
                    f.ctype = ADDR_ONLY;
                end
            end
            default: begin
                f.cmd   = FL_RDSR;
                f.ctype = CMD_RD;
                f.nmiso = 7'd8;
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/spi_fl_cmd_seq.sv
// Flash op sequencer: expands READ/PROGRAM/ERASE/RDSR requests into ordered
// spi_master_fl transactions (WREN prefix, status polling, address stepping).
module spi_fl_cmd_seq
    import spi_fl_pkg::*;
#(
    parameter int POLL_MAX = 1024,
    parameter int POLL_GAP = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [23:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [7:0]  req_nwords_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_last_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic [7:0]  fl_command_o,
    output logic [23:0] fl_address_o,
    output logic [31:0] fl_data_in_o,
    output logic [2:0]  fl_commtype_o,
    output logic [6:0]  fl_nmiso_bits_o,
    output logic [3:0]  fl_dummy_cycles_o,
    output logic [7:0]  fl_frame_struct_o,
    output logic        fl_validflag_o,
    input  logic        fl_tready_i,
    input  logic [31:0] fl_data_out_i,
    input  logic        fl_validflag_out_i
);

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int GW = $clog2(POLL_GAP + 1);

    state_e      state_q, state_d;
    step_e       step_q, step_d;
    op_e         op_q, op_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_last_q, rsp_last_d;
    logic        rsp_err_q, rsp_err_d;
    fl_frame_t   frame_q, frame_d;
    logic        fl_vld_q, fl_vld_d;
    logic        rdy_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            step_q     <= STEP_READ;
            op_q       <= OP_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            poll_q     <= '0;
            gap_q      <= '0;
            rsp_data_q <= '0;
            rsp_last_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            frame_q    <= '0;
            fl_vld_q   <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            poll_q     <= poll_d;
            gap_q      <= gap_d;
            rsp_data_q <= rsp_data_d;
            rsp_last_q <= rsp_last_d;
            rsp_err_q  <= rsp_err_d;
            frame_q    <= frame_d;
            fl_vld_q   <= fl_vld_d;
            rdy_q      <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        poll_d     = poll_q;
        gap_d      = gap_q;
        rsp_data_d = rsp_data_q;
        rsp_last_d = rsp_last_q;
        rsp_err_d  = rsp_err_q;
        frame_d    = frame_q;
        fl_vld_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    op_d    = op_e'(req_op_i);
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    cnt_d   = (req_nwords_i == 8'd0) ? 8'd1 : req_nwords_i;
                    poll_d  = '0;
                    case (op_e'(req_op_i))
                        OP_READ:  step_d = STEP_READ;
                        OP_RDSR:  step_d = STEP_RDSR;
                        default:  step_d = STEP_WREN;
                    endcase
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Frame fields and the start pulse register together so the
                // master sees a coherent descriptor on the pulse cycle.
                if (fl_tready_i) begin
                    frame_d  = frame_for(step_q, op_q, addr_q, wdata_q);
                    fl_vld_d = 1'b1;
                    if (step_q == STEP_POLL) poll_d = poll_q + 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fl_validflag_out_i) begin
                    rsp_err_d = 1'b0;
                    case (step_q)
                        STEP_READ: begin
                            rsp_data_d = fl_data_out_i;
                            rsp_last_d = (cnt_q == 8'd1);
                            state_d    = ST_RESP;
                        end
                        STEP_WREN: begin
                            step_d  = STEP_MAIN;
                            state_d = ST_ISSUE;
                        end
                        STEP_MAIN: begin
                            step_d  = STEP_POLL;
                            poll_d  = '0;
                            state_d = ST_ISSUE;
                        end
                        STEP_POLL: begin
                            rsp_data_d = {24'd0, fl_data_out_i[7:0]};
                            rsp_last_d = 1'b1;
                            if (!fl_data_out_i[0]) begin
                                state_d = ST_RESP;
                            end else if (poll_q == PW'(POLL_MAX)) begin
                                rsp_err_d = 1'b1;
                                state_d   = ST_RESP;
                            end else begin
                                gap_d   = '0;
                                state_d = ST_GAP;
                            end
                        end
                        default: begin
                            rsp_data_d = {24'd0, fl_data_out_i[7:0]};
                            rsp_last_d = 1'b1;
                            state_d    = ST_RESP;
                        end
                    endcase
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    if (step_q == STEP_READ && !rsp_last_q) begin
                        addr_d  = addr_q + 24'd4;
                        cnt_d   = cnt_q - 8'd1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GW'(POLL_GAP - 1)) state_d = ST_ISSUE;
                else                            gap_d   = gap_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready_o       = (state_q == ST_IDLE) && rdy_q;
    assign busy_o            = (state_q != ST_IDLE);
    assign rsp_valid_o       = (state_q == ST_RESP);
    assign rsp_data_o        = rsp_data_q;
    assign rsp_last_o        = rsp_last_q;
    assign rsp_err_o         = rsp_err_q;
    assign fl_command_o      = frame_q.cmd;
    assign fl_address_o      = frame_q.addr;
    assign fl_data_in_o      = frame_q.din;
    assign fl_commtype_o     = frame_q.ctype;
    assign fl_nmiso_bits_o   = frame_q.nmiso;
    assign fl_dummy_cycles_o = frame_q.dummy;
    assign fl_frame_struct_o = 8'h00;
    assign fl_validflag_o    = fl_vld_q;

endmodule

// File: tb/tb_spi_fl_cmd_seq.sv
// Bench for spi_fl_cmd_seq: behavioural spi_master_fl model plus frame and
// response scoreboards filled as each op is requested.
module tb_spi_fl_cmd_seq;

    localparam int PMAX = 4;
    localparam int PGAP = 16;
    localparam int BUSY = 40;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [2:0]  ct;
        logic [23:0] addr;
        logic [31:0] din;
        logic [6:0]  nmiso;
        logic [3:0]  dummy;
    } frm_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [1:0]  req_op = '0;
    logic [23:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [7:0]  req_nwords = '0;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_last, rsp_err, busy;
    logic [7:0]  fl_command, fl_frame_struct;
    logic [23:0] fl_address;
    logic [31:0] fl_data_in;
    logic [2:0]  fl_commtype;
    logic [6:0]  fl_nmiso_bits;
    logic [3:0]  fl_dummy_cycles;
    logic        fl_validflag;
    logic        fl_tready = 1'b1;
    logic [31:0] fl_data_out = '0;
    logic        fl_validflag_out = 1'b0;

    always #5 clk = ~clk;

    spi_fl_cmd_seq #(.POLL_MAX(PMAX), .POLL_GAP(PGAP)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_nwords_i(req_nwords),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_last_o(rsp_last), .rsp_err_o(rsp_err), .busy_o(busy),
        .fl_command_o(fl_command), .fl_address_o(fl_address), .fl_data_in_o(fl_data_in),
        .fl_commtype_o(fl_commtype), .fl_nmiso_bits_o(fl_nmiso_bits),
        .fl_dummy_cycles_o(fl_dummy_cycles), .fl_frame_struct_o(fl_frame_struct),
        .fl_validflag_o(fl_validflag), .fl_tready_i(fl_tready),
        .fl_data_out_i(fl_data_out), .fl_validflag_out_i(fl_validflag_out)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    frm_t       fq[$];
    rsp_t       rq[$];
    logic [7:0] sq[$];
    int frames = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    function automatic frm_t f_fread(input logic [23:0] a);
        return '{8'h0B, 3'd2, a, 32'h0, 7'd32, 4'd8};
    endfunction
    function automatic frm_t f_wren();
        return '{8'h06, 3'd0, 24'h0, 32'h0, 7'd0, 4'd0};
    endfunction
    function automatic frm_t f_rdsr();
        return '{8'h05, 3'd1, 24'h0, 32'h0, 7'd8, 4'd0};
    endfunction
    function automatic logic [31:0] rd_word(input logic [23:0] a);
        return {8'hC3, a};
    endfunction

    // spi_master_fl model: busy BUSY cycles per frame, then a done pulse.
    initial begin : master
        frm_t got, e;
        logic [31:0] d;
        int bad, prev_cyc;
        logic prev_rdsr;
        prev_rdsr = 1'b0;
        prev_cyc  = 0;
        forever begin
            @(negedge clk);
            if (fl_validflag === 1'b1) begin
                got = '{fl_command, fl_commtype, fl_address, fl_data_in, fl_nmiso_bits, fl_dummy_cycles};
                frames++;
                chk("vf_when_ready", fl_tready, 1'b1);
                chk("frame_struct", fl_frame_struct, 8'h00);
                chk("frame_expected", fq.size() != 0, 1'b1);
                if (fq.size() != 0) begin
                    e = fq.pop_front();
                    chk("frame", got, e);
                end
                if (got.cmd == 8'h05 && prev_rdsr)
                    chk("poll_spacing", (cyc - prev_cyc >= BUSY + PGAP + 1) &&
                                        (cyc - prev_cyc <= BUSY + PGAP + 3), 1'b1);
                prev_rdsr = (got.cmd == 8'h05);
                prev_cyc  = cyc;
                if (got.cmd == 8'h05)      d = (sq.size() != 0) ? {24'd0, sq.pop_front()} : 32'h0;
                else if (got.cmd == 8'h0B) d = rd_word(got.addr);
                else                       d = 32'h0;
                fl_tready = 1'b0;
                bad = 0;
                repeat (BUSY) begin
                    @(negedge clk);
                    if (fl_validflag !== 1'b0) bad++;
                end
                chk("vf_single_pulse", bad, 0);
                fl_data_out      = d;
                fl_validflag_out = 1'b1;
                @(negedge clk);
                fl_validflag_out = 1'b0;
                fl_tready        = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : rsp_mon
        rsp_t er;
        if (rst_n && rsp_valid && rsp_ready) begin
            chk("rsp_expected", rq.size() != 0, 1'b1);
            if (rq.size() != 0) begin
                er = rq.pop_front();
                chk("rsp_data", rsp_data, er.data);
                chk("rsp_last", rsp_last, er.last);
                chk("rsp_err", rsp_err, er.err);
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [23:0] a,
                        input logic [31:0] wd, input logic [7:0] nw);
        int t;
        t = 0;
        @(posedge clk); #2;
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd; req_nwords = nw;
        do begin @(negedge clk); t++; end while (!req_ready && t < 2000);
        chk("req_accept", req_ready, 1'b1);
        @(posedge clk); #2;
        req_valid  = 1'b0;
        req_op     = 2'($urandom);
        req_addr   = 24'($urandom);
        req_wdata  = $urandom;
        req_nwords = 8'($urandom);
    endtask

    task automatic wait_done(input int lim);
        int t;
        t = 0;
        while ((busy || rq.size() != 0 || fq.size() != 0) && t < lim) begin
            @(negedge clk); t++;
        end
        chk("op_done_in_time", t < lim, 1'b1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end

    initial begin : stim
        int f0, bad, t;
        logic [31:0] d0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_vf", fl_validflag, 1'b0);
        chk("rst_fields", {fl_command, fl_address, fl_data_in, fl_commtype, rsp_data}, '0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rdy_after_rst", req_ready, 1'b1);

        // READ burst of 3
        for (int i = 0; i < 3; i++) begin
            fq.push_back(f_fread(24'h000100 + 24'(4 * i)));
            rq.push_back('{rd_word(24'h000100 + 24'(4 * i)), i == 2, 1'b0});
        end
        send(2'd0, 24'h000100, 32'h0, 8'd3);
        wait_done(5000);

        // READ wrapping the 24-bit address space
        fq.push_back(f_fread(24'hFFFFFC)); rq.push_back('{rd_word(24'hFFFFFC), 1'b0, 1'b0});
        fq.push_back(f_fread(24'h000000)); rq.push_back('{rd_word(24'h000000), 1'b1, 1'b0});
        send(2'd0, 24'hFFFFFC, 32'h0, 8'd2);
        wait_done(5000);

        // nwords 0 behaves as a single word
        fq.push_back(f_fread(24'h000020)); rq.push_back('{rd_word(24'h000020), 1'b1, 1'b0});
        send(2'd0, 24'h000020, 32'h0, 8'd0);
        wait_done(5000);

        // PROGRAM: WREN, PP, three polls
        sq = '{8'h03, 8'h03, 8'h00};
        fq.push_back(f_wren());
        fq.push_back('{8'h02, 3'd4, 24'h000200, 32'hA0A0A0A3, 7'd0, 4'd0});
        repeat (3) fq.push_back(f_rdsr());
        rq.push_back('{32'h0, 1'b1, 1'b0});
        send(2'd1, 24'h000200, 32'hA0A0A0A3, 8'd0);
        wait_done(5000);

        // ERASE with WIP stuck: poll budget exhausted
        sq = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        fq.push_back(f_wren());
        fq.push_back('{8'h20, 3'd5, 24'h010000, 32'h0, 7'd0, 4'd0});
        repeat (PMAX) fq.push_back(f_rdsr());
        rq.push_back('{32'h1, 1'b1, 1'b1});
        send(2'd2, 24'h010000, 32'h0, 8'd0);
        wait_done(5000);
        sq.delete();

        // READ with response back-pressure
        @(posedge clk); #2 rsp_ready = 1'b0;
        fq.push_back(f_fread(24'h000400)); rq.push_back('{rd_word(24'h000400), 1'b0, 1'b0});
        fq.push_back(f_fread(24'h000404)); rq.push_back('{rd_word(24'h000404), 1'b1, 1'b0});
        send(2'd0, 24'h000400, 32'h0, 8'd2);
        t = 0;
        while (!rsp_valid && t < 1000) begin @(negedge clk); t++; end
        chk("stall_rsp_seen", rsp_valid, 1'b1);
        f0 = frames; d0 = rsp_data; bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== d0) bad++;
        end
        chk("stall_rsp_held", bad, 0);
        chk("stall_no_issue", frames, f0);
        chk("stall_req_blocked", req_ready, 1'b0);
        @(posedge clk); #2 rsp_ready = 1'b1;
        wait_done(5000);

        // Reset during the PP frame, then a clean RDSR op
        fq.push_back(f_wren());
        fq.push_back('{8'h02, 3'd4, 24'h000300, 32'h12345678, 7'd0, 4'd0});
        f0 = frames;
        send(2'd1, 24'h000300, 32'h12345678, 8'd0);
        t = 0;
        while (frames < f0 + 2 && t < 2000) begin @(negedge clk); t++; end
        chk("pp_frame_seen", frames, f0 + 2);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_vf", fl_validflag, 1'b0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_req_ready", req_ready, 1'b0);
        chk("mid_rst_fields", {fl_command, fl_address, fl_data_in, fl_commtype}, '0);
        fq.delete(); rq.delete();
        @(posedge clk); #2 rst_n = 1'b1;
        sq.push_back(8'h42);
        fq.push_back(f_rdsr());
        rq.push_back('{32'h42, 1'b1, 1'b0});
        send(2'd3, 24'h0, 32'h0, 8'd0);
        wait_done(5000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
